issueint_pipe: RTL
==================

# issueint_pipe

Parametrised, pipelined integer execution unit for the out-of-order core's integer issue queue. It accepts one issued ALU operation per cycle with its destination tag and carries the tag alongside the data. It returns the result, the carry and overflow flags and a trap request to the common data bus arbiter through a valid/ready handshake. Pipeline depth is configurable, and the whole pipe supports backpressure and flush.

## Interface
- DATA_W, 32: operand/result width (≥8, power of two).
- TAG_W, 6: rename tag width.
- STAGES, 2: pipeline depth, 1..4; equals result latency.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset: asynchronous, active-low.
- issue_valid  in  1  operation offered.
- issue_ready  out  1  unit can accept this cycle.
- issue_opcode  in  4  operation select.
- issue_rsdata  in  DATA_W  operand A.
- issue_rtdata  in  DATA_W  operand B (shift amount in low log2(DATA_W) bits).
- issue_rdtag  in  TAG_W  destination tag.
- flush  in  1  squash all in-flight operations.
- out_valid  out  1  result available at final stage.
- out_ready  in  1  CDB grant; result consumed when out_valid&&out_ready.
- out_data  out  DATA_W  result.
- out_rdtag  out  TAG_W  tag of result.
- out_carryout  out  1  adder carry-out.
- out_overflow  out  1  signed overflow.
- out_trap  out  1  overflow trap request.
- occupancy  out  $clog2(STAGES+1)  valid entries in pipe.

## Operation
- Opcodes: ADD 0000, ADDU 0001, SUB 0010, SUBU 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, SLL 1000, SRL 1001, SLT 1010, SLTU 1011, SRA 1100. Codes 1101–1111 give out_data=0 with all flags 0.
- ADD/ADDU: A+B. SUB/SUBU: A+~B+1. out_carryout is the carry from bit DATA_W-1; for subtraction, carry=1 means no borrow. For all other opcodes out_carryout=0.
- out_overflow is signed overflow for ADD, ADDU, SUB and SUBU, and 0 otherwise. out_trap=out_overflow only for ADD and SUB; ADDU and SUBU never trap.
- SLT: signed A<B gives 1, else 0, zero-extended. SLTU: same compare, unsigned.
- Shifts: shift amount is B[log2(DATA_W)-1:0], applied to A. SRA replicates A's MSB.
- The result is computed combinationally on the issue inputs and registered into stage 1. Stages 2..STAGES only delay data, tag and flags.
- Each stage holds a valid bit. Stage i loads from stage i-1 when stage i is empty or stage i is advancing. The final stage advances when out_ready=1. Bubbles collapse.
- issue_ready = !flush && (stage 1 empty || stage 1 advancing).
- Ordering: results leave in issue order. Nothing is dropped or duplicated under backpressure.
- flush: all valid bits clear at the next edge. An issue offered in the flush cycle is not accepted (issue_ready=0). A result handshaking in the flush cycle still counts as consumed.
- occupancy equals the number of set stage valid bits.

## Timing
- Reset (rst=0): all valid bits 0. out_valid=0, out_data=0, out_rdtag=0, out_carryout=0, out_overflow=0, out_trap=0, occupancy=0, issue_ready=0 while asserted.
- Reset deasserted mid-operation: all in-flight work is lost. issue_ready=1 on the first cycle after release.
- Latency: an operation accepted at edge N shows out_valid=1 after edge N+STAGES-1 when unstalled, and presents from cycle N+STAGES onward.
- Throughput: one operation per cycle with out_ready held 1.
- Stall: with out_ready=0 and continuous issue, the pipe fills to STAGES entries and issue_ready falls in the same cycle stage 1 is full and blocked. When out_ready rises, issue_ready rises combinationally in that cycle.
- Outputs are registered except issue_ready, which is combinational from valids, out_ready and flush.

## Test plan
- Reset, then ADD 0x7FFFFFFF+0x00000001 tag 5 → out_data 0x80000000, rdtag 5, overflow 1, trap 1, carry 0, after exactly STAGES cycles.
- Same operands with ADDU → overflow 1, trap 0. SUB 0x00000000−0x00000001 → out_data 0xFFFFFFFF, carry 0, overflow 0.
- SLT 0xFFFFFFFF,0x00000001 → 1. SLTU, same operands → 0. SRA 0x80000000 by 4 → 0xF8000000. SRL by 4 → 0x08000000. NOR 0,0 → 0xFFFFFFFF.
- Back-to-back issue of tags 1..8 with out_ready held 0 for 6 cycles, then 1 → occupancy reaches STAGES, issue_ready 0 while full, all 8 tags delivered in order with correct results.
- Fill the pipe, assert flush together with issue_valid → next cycle occupancy 0 and out_valid 0. The flush-cycle issue is not accepted and never appears at the output.
- Assert rst low with the pipe full and out_ready 0 → outputs clear asynchronously. After release, a new ADD 2+3 → 5 with normal latency.

Source files
------------

// File: rtl/issueint_pipe.sv
// Pipelined integer ALU for the integer issue queue: registered result, tag and
// flags, with valid/ready backpressure, bubble collapse and flush.
module issueint_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [3:0]                  issue_opcode,
  input  logic [DATA_W-1:0]           issue_rsdata,
  input  logic [DATA_W-1:0]           issue_rtdata,
  input  logic [TAG_W-1:0]            issue_rdtag,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [TAG_W-1:0]            out_rdtag,
  output logic                        out_carryout,
  output logic                        out_overflow,
  output logic                        out_trap,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int OCC_W = $clog2(STAGES+1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_ADDU = 4'b0001, OP_SUB  = 4'b0010, OP_SUBU = 4'b0011,
    OP_AND  = 4'b0100, OP_OR   = 4'b0101, OP_XOR  = 4'b0110, OP_NOR  = 4'b0111,
    OP_SLL  = 4'b1000, OP_SRL  = 4'b1001, OP_SLT  = 4'b1010, OP_SLTU = 4'b1011,
    OP_SRA  = 4'b1100
  } opcode_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              carry;
    logic              ovf;
    logic              trap;
  } entry_t;

  // ---------------------------------------------------------------- ALU
  logic              w_is_add;
  logic              w_is_sub;
  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_sum;
  logic              w_ovf;
  logic [SH_W-1:0]   w_shamt;
  entry_t            w_alu;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_alu      = '0;
    w_alu.tag  = issue_rdtag;
    w_is_add   = (issue_opcode == OP_ADD) || (issue_opcode == OP_ADDU);
    w_is_sub   = (issue_opcode == OP_SUB) || (issue_opcode == OP_SUBU);
    w_b_eff    = w_is_sub ? ~issue_rtdata : issue_rtdata;
    w_sum      = {1'b0, issue_rsdata} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, w_is_sub};
    // Signed overflow: operands agree in sign but the sum does not.
    w_ovf      = (issue_rsdata[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                 (w_sum[DATA_W-1] != issue_rsdata[DATA_W-1]);
    w_shamt    = issue_rtdata[SH_W-1:0];

    case (issue_opcode)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: begin
        w_alu.data  = w_sum[DATA_W-1:0];
        w_alu.carry = w_sum[DATA_W];
        w_alu.ovf   = w_ovf;
        w_alu.trap  = w_ovf && ((issue_opcode == OP_ADD) || (issue_opcode == OP_SUB));
      end
      OP_AND:  w_alu.data = issue_rsdata & issue_rtdata;
      OP_OR:   w_alu.data = issue_rsdata | issue_rtdata;
      OP_XOR:  w_alu.data = issue_rsdata ^ issue_rtdata;
      OP_NOR:  w_alu.data = ~(issue_rsdata | issue_rtdata);
      OP_SLL:  w_alu.data = issue_rsdata << w_shamt;
      OP_SRL:  w_alu.data = issue_rsdata >> w_shamt;
      OP_SRA:  w_alu.data = DATA_W'($signed(issue_rsdata) >>> w_shamt);
      OP_SLT:  w_alu.data = {{(DATA_W-1){1'b0}}, $signed(issue_rsdata) < $signed(issue_rtdata)};
      OP_SLTU: w_alu.data = {{(DATA_W-1){1'b0}}, issue_rsdata < issue_rtdata};
      default: w_alu.data = '0;
    endcase
  end

  // ---------------------------------------------------------- pipeline
  entry_t              r_entry [STAGES];
  logic [STAGES-1:0]   r_valid;
  logic [OCC_W-1:0]    r_occ;
  logic [STAGES-1:0]   w_load;
  logic [STAGES-1:0]   w_valid_nxt;
  logic [OCC_W-1:0]    w_occ_nxt;
  logic                w_hole;

  // A stage may load when it is empty or something downstream can move:
  // either the final stage is drained or there is a bubble further down.
  always_comb begin
    w_hole = out_ready;
    w_load = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      w_load[i] = !r_valid[i] || w_hole;
      w_hole    = w_hole || !r_valid[i];
    end
  end

  assign issue_ready = rst && !flush && w_load[0];

  always_comb begin
    w_valid_nxt = r_valid;
    w_occ_nxt   = '0;
    if (flush) begin
      w_valid_nxt = '0;
    end else begin
      if (w_load[0]) w_valid_nxt[0] = issue_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (w_load[i]) w_valid_nxt[i] = r_valid[i-1];
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values of its neighbour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_occ   <= '0;
      // NOTE: the stage payloads are ordinary flops and are cleared too, so outputs read 0 in reset.
      for (int i = 0; i < STAGES; i++) r_entry[i] <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
      if (!flush) begin
        if (w_load[0] && issue_valid) r_entry[0] <= w_alu;
        for (int i = 1; i < STAGES; i++) begin
          if (w_load[i] && r_valid[i-1]) r_entry[i] <= r_entry[i-1];
        end
      end
    end
  end

  assign out_valid    = r_valid[STAGES-1];
  assign out_data     = r_entry[STAGES-1].data;
  assign out_rdtag    = r_entry[STAGES-1].tag;
  assign out_carryout = r_entry[STAGES-1].carry;
  assign out_overflow = r_entry[STAGES-1].ovf;
  assign out_trap     = r_entry[STAGES-1].trap;
  assign occupancy    = r_occ;

endmodule
